// File: rtl/tx_report_mux.sv
// tx_report_mux: merges FIFO-buffered echo bytes and atomic "\r"+8-hex-digit reports onto one tx port.
module tx_report_mux #(
  parameter int FIFO_AW = 4,
  parameter int REPEAT_CYCLES = 100000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         echo_data,
  input  logic               echo_valid,
  input  logic [31:0]        report_value,
  input  logic               report_valid,
  input  logic               tx_busy,
  output logic [7:0]         tx_data,
  output logic               new_tx_data,
  output logic               busy,
  output logic               echo_overflow,
  output logic [FIFO_AW:0]   fifo_count
);
  localparam logic IDLE = 1'b0;
  localparam logic REPORT = 1'b1;
  localparam logic [31:0] RELOAD = 32'(REPEAT_CYCLES - 1);
  logic [7:0] mem [2**FIFO_AW];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0] count;
  logic state, pending;
  logic [31:0] pend_val, shift, timer;
  logic [3:0] digits;
  logic slot, push, pop, req, start, dig;
  logic [7:0] hex;
  always_comb begin
    slot = !tx_busy && !new_tx_data;
    push = echo_valid && !count[FIFO_AW];
    req = report_valid || (REPEAT_CYCLES > 0 && timer == 32'd0);
    start = state == IDLE && slot && pending;
    pop = state == IDLE && slot && !pending && count != '0;
    dig = state == REPORT && slot;
    hex = shift[31:28] < 4'd10 ? 8'h30 + {4'h0, shift[31:28]} : 8'h57 + {4'h0, shift[31:28]};
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= echo_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data <= 8'h00;
      new_tx_data <= 1'b0;
      echo_overflow <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      state <= IDLE;
      pending <= 1'b0;
      pend_val <= 32'd0;
      shift <= 32'd0;
      digits <= 4'd0;
      timer <= RELOAD;
    end else begin
      timer <= req ? RELOAD : timer - 32'd1;
      if (req) pend_val <= report_value;
      // a request in the start cycle keeps pending set for the next report
      pending <= req || (pending && !start);
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
      count <= count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
      if (echo_valid && count[FIFO_AW]) echo_overflow <= 1'b1;
      new_tx_data <= start || dig || pop;
      if (start) tx_data <= 8'h0D;
      else if (dig) tx_data <= hex;
      else if (pop) tx_data <= mem[rd_ptr];
      if (start) begin
        shift <= pend_val;
        digits <= 4'd8;
        state <= REPORT;
      end else if (dig) begin
        shift <= shift << 4;
        digits <= digits - 4'd1;
        if (digits == 4'd1) state <= IDLE;
      end
    end
  end
  assign busy = state == REPORT;
  assign fifo_count = count;
endmodule

// File: tb/tb_tx_report_mux.sv
// tb_tx_report_mux: scoreboard bench for tx_report_mux plus timer-enabled and timer-disabled instances.
module tb_tx_report_mux;
  logic clk = 0, rst = 1, rst_aux = 1;
  logic [7:0] echo_data = 0;
  logic echo_valid = 0, report_valid = 0, tx_busy = 0;
  logic [31:0] report_value = 0;
  logic [7:0] tx_data, t_data, z_data;
  logic new_tx_data, busy, echo_overflow;
  logic t_new, t_busy, t_ovf, z_new, z_busy, z_ovf;
  logic [4:0] fifo_count, t_cnt, z_cnt;
  int checks = 0, errors = 0, cyc = 0;
  int strb_n = 0, first_strb = -1, last_strb = -1, busy_n = 0;
  int t_idx = 0, t_last = -1, t_cr = 0, z_strb = 0;
  logic [7:0] q[$];

  tx_report_mux dut (.clk(clk), .rst(rst), .echo_data(echo_data), .echo_valid(echo_valid),
    .report_value(report_value), .report_valid(report_valid), .tx_busy(tx_busy), .tx_data(tx_data),
    .new_tx_data(new_tx_data), .busy(busy), .echo_overflow(echo_overflow), .fifo_count(fifo_count));
  tx_report_mux #(.REPEAT_CYCLES(50)) dut_t (.clk(clk), .rst(rst_aux), .echo_data(8'h00), .echo_valid(1'b0),
    .report_value(32'hA), .report_valid(1'b0), .tx_busy(1'b0), .tx_data(t_data),
    .new_tx_data(t_new), .busy(t_busy), .echo_overflow(t_ovf), .fifo_count(t_cnt));
  tx_report_mux #(.REPEAT_CYCLES(0)) dut_z (.clk(clk), .rst(rst_aux), .echo_data(8'h00), .echo_valid(1'b0),
    .report_value(32'hA), .report_valid(1'b0), .tx_busy(1'b0), .tx_data(z_data),
    .new_tx_data(z_new), .busy(z_busy), .echo_overflow(z_ovf), .fifo_count(z_cnt));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_n++;
      if (new_tx_data) begin
        strb_n++;
        if (first_strb < 0) first_strb = cyc;
        last_strb = cyc;
        if (q.size() == 0) chk("extra_byte", {24'h0, tx_data}, 32'h100);
        else chk("tx_byte", {24'h0, tx_data}, {24'h0, q.pop_front()});
      end
    end
    if (!rst_aux) begin
      if (z_new) z_strb++;
      if (t_new) begin
        chk("timer_byte", {24'h0, t_data}, t_idx == 0 ? 32'h0D : t_idx == 8 ? 32'h61 : 32'h30);
        if (t_idx == 0) begin
          if (t_last >= 0) chk("timer_period", cyc - t_last, 50);
          t_last = cyc;
          t_cr++;
        end
        t_idx = (t_idx + 1) % 9;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_report(input logic [31:0] v);
    string s = $sformatf("%08h", v);
    q.push_back(8'h0D);
    for (int i = 0; i < 8; i++) q.push_back(s[i]);
  endtask

  task automatic pulse_report(input logic [31:0] v);
    report_value = v;
    report_valid = 1;
    tick();
    report_valid = 0;
  endtask

  task automatic echo(input logic [7:0] b);
    echo_data = b;
    echo_valid = 1;
    tick();
    echo_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || busy || fifo_count != 0) && n < 3000) begin
      tick();
      n++;
    end
    chk("drain", {29'h0, q.size() != 0, busy, fifo_count != 0}, 0);
    repeat (4) tick();
  endtask

  initial begin
    int pc, n;
    repeat (3) tick();
    rst = 0;
    rst_aux = 0;
    tick();
    chk("rst_tx_data", {24'h0, tx_data}, 0);
    chk("rst_new", {31'h0, new_tx_data}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_ovf", {31'h0, echo_overflow}, 0);
    chk("rst_count", {27'h0, fifo_count}, 0);
    exp_report(32'h0000BEEF);
    first_strb = -1;
    busy_n = 0;
    report_value = 32'h0000BEEF;
    report_valid = 1;
    pc = cyc;
    tick();
    report_valid = 0;
    drain();
    chk("first_latency", first_strb - pc, 2);
    chk("report_span", last_strb - first_strb, 16);
    chk("busy_span", busy_n, 16);
    tx_busy = 1;
    for (int i = 0; i < 17; i++) begin
      echo_data = 8'(8'h41 + i);
      echo_valid = 1;
      if (i < 16) q.push_back(echo_data);
      tick();
    end
    echo_valid = 0;
    tick();
    chk("full_count", {27'h0, fifo_count}, 16);
    chk("ovf_set", {31'h0, echo_overflow}, 1);
    tx_busy = 0;
    drain();
    chk("ovf_sticky", {31'h0, echo_overflow}, 1);
    q.push_back(8'h61);
    q.push_back(8'h62);
    exp_report(32'h12345678);
    q.push_back(8'h63);
    echo_data = 8'h61; echo_valid = 1; tick();
    echo_data = 8'h62; tick();
    echo_data = 8'h63; tick();
    echo_valid = 0;
    pulse_report(32'h12345678);
    drain();
    exp_report(32'h0);
    exp_report(32'h3);
    pulse_report(32'h0);
    tick(); tick();
    pulse_report(32'h1);
    tick();
    pulse_report(32'h2);
    tick();
    pulse_report(32'h3);
    drain();
    exp_report(32'hCAFEF00D);
    strb_n = 0;
    pulse_report(32'hCAFEF00D);
    echo(8'h71);
    echo(8'h72);
    n = 0;
    while (strb_n < 5 && n < 100) begin
      tick();
      n++;
    end
    chk("rst_reach", strb_n, 5);
    chk("fifo_pre_rst", {27'h0, fifo_count}, 2);
    rst = 1;
    q.delete();
    tick(); tick();
    rst = 0;
    chk("post_rst_new", {31'h0, new_tx_data}, 0);
    chk("post_rst_busy", {31'h0, busy}, 0);
    chk("post_rst_count", {27'h0, fifo_count}, 0);
    chk("post_rst_data", {24'h0, tx_data}, 0);
    repeat (10) tick();
    exp_report(32'h9);
    pulse_report(32'h9);
    drain();
    repeat (300) tick();
    chk("timer_reports", {31'h0, t_cr >= 5}, 1);
    chk("zero_timer", z_strb, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
